// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for a 5-stage MIPS pipeline with a mul/div hold FSM.
// Optional stall-cycle counter is built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_D,
  input  logic [REG_AW-1:0] rt_D,
  input  logic              branch_D,
  input  logic              pc_src_D,
  input  logic [REG_AW-1:0] rs_E,
  input  logic [REG_AW-1:0] rt_E,
  input  logic [REG_AW-1:0] writereg_E,
  input  logic              regwrite_E,
  input  logic              memtoreg_E,
  input  logic              muldiv_start_E,
  input  logic [REG_AW-1:0] writereg_M,
  input  logic              regwrite_M,
  input  logic              memtoreg_M,
  input  logic [REG_AW-1:0] writereg_W,
  input  logic              regwrite_W,
  output logic              stall_F,
  output logic              stall_D,
  output logic              stall_E,
  output logic              flush_D,
  output logic              flush_E,
  output logic              flush_M,
  output logic [1:0]        forwardA_E,
  output logic [1:0]        forwardB_E,
  output logic              forwardA_D,
  output logic              forwardB_D,
  output logic              muldiv_busy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned CW = $clog2(MULDIV_LAT + 1);

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

  md_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic          md_stall, lw_stall, br_stall, stall_any;

  function automatic logic nz(input logic [REG_AW-1:0] r);
    return |r;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [REG_AW-1:0] src,
                                       input logic rw_m, input logic [REG_AW-1:0] wr_m,
                                       input logic rw_w, input logic [REG_AW-1:0] wr_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (rw_m && nz(src) && (src == wr_m))      sel = 2'b10;
    else if (rw_w && nz(src) && (src == wr_w)) sel = 2'b01;
    return sel;
  endfunction

  // Op is accepted from IDLE; BUSY counts down the remaining MULDIV_LAT-1 stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        MD_IDLE: if (muldiv_start_E) begin
          state_q <= MD_BUSY;
          cnt_q   <= CW'(MULDIV_LAT - 2);
        end
        MD_BUSY: if (cnt_q == '0) state_q <= MD_DONE;
                 else             cnt_q   <= cnt_q - CW'(1);
        MD_DONE: state_q <= MD_IDLE;
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  always_comb begin
    md_stall = ~reset & (((state_q == MD_IDLE) & muldiv_start_E) | (state_q == MD_BUSY));
    lw_stall = ~reset & memtoreg_E & nz(writereg_E) &
               ((rs_D == writereg_E) | (rt_D == writereg_E));
    br_stall = ~reset & branch_D &
               ((regwrite_E & nz(writereg_E) & ((rs_D == writereg_E) | (rt_D == writereg_E))) |
                (memtoreg_M & nz(writereg_M) & ((rs_D == writereg_M) | (rt_D == writereg_M))));
    stall_any = md_stall | lw_stall | br_stall;
  end

  assign stall_F     = stall_any;
  assign stall_D     = stall_any;
  assign stall_E     = md_stall;
  assign flush_M     = md_stall;
  // A held E stage must keep its instruction, so no bubble while mul/div stalls.
  assign flush_E     = (lw_stall | br_stall) & ~md_stall;
  assign flush_D     = ~reset & pc_src_D & ~stall_any;
  assign muldiv_busy = (state_q != MD_IDLE);

  assign forwardA_E = fwd_e(rs_E, regwrite_M, writereg_M, regwrite_W, writereg_W);
  assign forwardB_E = fwd_e(rt_E, regwrite_M, writereg_M, regwrite_W, writereg_W);
  assign forwardA_D = regwrite_M & nz(rs_D) & (rs_D == writereg_M);
  assign forwardB_D = regwrite_M & nz(rt_D) & (rt_D == writereg_M);

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_any && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cycles_q <= '0;
    else       stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
